i2s_receiver: RTL
=================

I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 24, bits per channel word.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sclk  input  1  I2S bit clock, asynchronous to clk.
REQ-005 SHALL have port lrclk  input  1  I2S word select; low = left slot, high = right slot.
REQ-006 SHALL have port sd  input  1  I2S serial data, MSB first.
REQ-007 SHALL have port left_data  output  WORD_SIZE  last complete left word.
REQ-008 SHALL have port right_data  output  WORD_SIZE  last complete right word.
REQ-009 SHALL have port valid  output  1  one-clk pulse: new stereo pair on left_data/right_data.
REQ-010 SHALL have port frame_error  output  1  one-clk pulse: slot length not WORD_SIZE.

Function
REQ-011 SHALL pass sclk, lrclk and sd each through a 2-flop synchronizer; all further logic uses synchronized copies only.
REQ-012 SHALL detect sclk rising edges as synced sclk = 1 while its previous-cycle value = 0; one event per edge.
REQ-013 SHALL require clk frequency >= 4x sclk; behaviour below that ratio is undefined.
REQ-014 SHALL, on each sclk event, sample synced sd and synced lrclk together.
REQ-015 SHALL treat an sclk event whose sampled lrclk differs from the previous event's sampled lrclk as a boundary; the sd bit at a boundary is the LSB of the word just ending (I2S one-bit delay).
REQ-016 On non-boundary events SHALL shift sd into a WORD_SIZE shift register LSB-side and increment bit counter, saturating at WORD_SIZE+1.
REQ-017 At a boundary, completed word SHALL be {shift[WORD_SIZE-2:0], sd}; word is good iff counter+1 == WORD_SIZE; counter then cleared to 0.
REQ-018 SHALL implement states SEEK, RX_LEFT, RX_RIGHT.
REQ-019 SEEK: low->high boundary ignored; high->low boundary -> RX_LEFT; no output activity.
REQ-020 RX_LEFT: low->high boundary, good word -> store in left holding register, -> RX_RIGHT.
REQ-021 RX_RIGHT: high->low boundary, good word -> left_data <= left holding, right_data <= word, valid = 1 one cycle, -> RX_LEFT.
REQ-022 Bad word in RX_LEFT or RX_RIGHT SHALL pulse frame_error one cycle, discard word, leave left_data/right_data/valid unchanged, -> SEEK.
REQ-023 left_data and right_data SHALL update in the same clk cycle valid asserts and hold until the next valid.
REQ-024 Latency: valid/frame_error SHALL assert exactly 4 clk rising edges after the first clk edge at which raw sclk reads 1 for the boundary edge.
REQ-025 valid and frame_error SHALL never assert in the same cycle.

Reset
REQ-026 While Reset = 1: left_data = 0, right_data = 0, valid = 0, frame_error = 0, state = SEEK, counter = 0, shift and holding registers = 0, synchronizers = 0.
REQ-027 Reset deassertion mid-frame SHALL resume in SEEK; first valid only after a full left slot then full right slot.

Verification
REQ-028 Reset, then 3 clean frames left 24'h010101, right 24'h101010 -> first frame discarded (SEEK), then valid once per frame with exactly those values; frame_error never.
REQ-029 Left 24'hFFFFFF, right 24'h000000, then left 24'h800001, right 24'h7FFFFE -> each pair output bit-exact; MSB/LSB order checked.
REQ-030 Right slot of 23 bits mid-stream -> frame_error pulse 4 clk after its boundary, no valid, outputs keep previous pair; next clean frame after re-alignment -> valid with new data.
REQ-031 Left slot of 25 bits -> frame_error, counter saturates without wrap, return to SEEK; recovery as above.
REQ-032 Reset asserted for 1 clk in middle of right slot -> all outputs 0 immediately (asynchronous), no valid for the partial frame, correct pair from next complete frame.
REQ-033 Loopback with I2S_Transmitter (WORD_SIZE 24, clk = 4x sclk minimum) driving 100 random pairs -> every received pair equals the pair transmitted, in order, after the first frame.

Source files
------------

// File: rtl/i2s_receiver.sv
// ---------------------------------------------------------------------------
// i2s_receiver
//
// Purpose: recovers stereo words from an I2S stream (sclk / lrclk / sd) that
// is asynchronous to the system clock. The three I2S wires are synchronized,
// sclk rising edges are detected, and the bits are assembled into
// WORD_SIZE-bit words using the I2S one-bit delay: the bit sampled on the
// edge where lrclk changes is the LSB of the word that is just ending.
// A stereo pair is published only after a complete left slot followed by a
// complete right slot. Any slot whose length is not WORD_SIZE raises
// frame_error, and the receiver then re-aligns on the next high->low lrclk
// transition.
//
// Ports:
//   clk         in   system clock, all logic on its rising edge
//   Reset       in   asynchronous, active-high reset
//   sclk        in   I2S bit clock (asynchronous, clk must be >= 4x sclk)
//   lrclk       in   I2S word select, 0 = left slot, 1 = right slot
//   sd          in   I2S serial data, MSB first
//   left_data   out  last complete left word
//   right_data  out  last complete right word
//   valid       out  one-clk pulse, a new pair is on left_data/right_data
//   frame_error out  one-clk pulse, a slot did not hold WORD_SIZE bits
//   state_dbg   out  current receiver state (SEEK=0, RX_LEFT=1, RX_RIGHT=2)
//
// Timing: valid/frame_error rise 4 clk edges after the first clk edge that
// sees raw sclk high for the boundary bit. The stages are: synchronizer
// (2 edges), event/sample register, word-assembly register, FSM output
// register.
// ---------------------------------------------------------------------------
module i2s_receiver #(
    parameter int WORD_SIZE = 24
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 sclk,
    input  logic                 lrclk,
    input  logic                 sd,
    output logic [WORD_SIZE-1:0] left_data,
    output logic [WORD_SIZE-1:0] right_data,
    output logic                 valid,
    output logic                 frame_error,
    output logic [1:0]           state_dbg
);

    localparam int CW = $clog2(WORD_SIZE + 2);

    typedef enum logic [1:0] {
        SEEK     = 2'd0,
        RX_LEFT  = 2'd1,
        RX_RIGHT = 2'd2
    } state_t;

    // Two-flop synchronizers plus the previous synced sclk value.
    logic sclk_meta, sclk_sync, sclk_last;
    logic lrclk_meta, lrclk_sync;
    logic sd_meta, sd_sync;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sclk_meta  <= 1'b0;
            sclk_sync  <= 1'b0;
            sclk_last  <= 1'b0;
            lrclk_meta <= 1'b0;
            lrclk_sync <= 1'b0;
            sd_meta    <= 1'b0;
            sd_sync    <= 1'b0;
        end else begin
            sclk_meta  <= sclk;
            sclk_sync  <= sclk_meta;
            sclk_last  <= sclk_sync;
            lrclk_meta <= lrclk;
            lrclk_sync <= lrclk_meta;
            sd_meta    <= sd;
            sd_sync    <= sd_meta;
        end
    end

    logic sclk_rise;
    assign sclk_rise = sclk_sync & ~sclk_last;

    // Event stage: capture lrclk and sd together on each sclk rising edge.
    logic ev_q, ev_lr, ev_sd;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            ev_q  <= 1'b0;
            ev_lr <= 1'b0;
            ev_sd <= 1'b0;
        end else begin
            ev_q  <= sclk_rise;
            ev_lr <= lrclk_sync;
            ev_sd <= sd_sync;
        end
    end

    // Word-assembly stage. At a boundary the incoming bit closes the old
    // word; otherwise it is shifted in and counted. The counter saturates one
    // past WORD_SIZE so an overlong slot can never wrap back to "good".
    logic                 lr_prev;
    logic [WORD_SIZE-1:0] shift_reg;
    logic [CW-1:0]        bit_cnt;
    logic                 bnd_q, bnd_rise_q, good_q;
    logic [WORD_SIZE-1:0] word_q;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            lr_prev    <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            bnd_q      <= 1'b0;
            bnd_rise_q <= 1'b0;
            good_q     <= 1'b0;
            word_q     <= '0;
        end else begin
            bnd_q <= 1'b0;
            if (ev_q) begin
                lr_prev <= ev_lr;
                if (ev_lr != lr_prev) begin
                    bnd_q      <= 1'b1;
                    bnd_rise_q <= ev_lr;
                    word_q     <= {shift_reg[WORD_SIZE-2:0], ev_sd};
                    good_q     <= (bit_cnt == CW'(WORD_SIZE - 1));
                    bit_cnt    <= '0;
                end else begin
                    shift_reg <= {shift_reg[WORD_SIZE-2:0], ev_sd};
                    if (bit_cnt != CW'(WORD_SIZE + 1)) begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
            end
        end
    end

    // Framing FSM: acts only on boundaries coming out of the assembly stage.
    state_t               state, state_next;
    logic [WORD_SIZE-1:0] hold_left;
    logic                 valid_next, ferr_next, load_hold, load_out;

    always_comb begin
        state_next = state;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        load_hold  = 1'b0;
        load_out   = 1'b0;
        if (bnd_q) begin
            case (state)
                SEEK: begin
                    // Only a high->low transition marks the start of a left slot.
                    if (!bnd_rise_q) begin
                        state_next = RX_LEFT;
                    end
                end
                RX_LEFT: begin
                    if (good_q) begin
                        load_hold  = 1'b1;
                        state_next = RX_RIGHT;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = SEEK;
                    end
                end
                RX_RIGHT: begin
                    if (good_q) begin
                        load_out   = 1'b1;
                        valid_next = 1'b1;
                        state_next = RX_LEFT;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = SEEK;
                    end
                end
                default: state_next = SEEK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state       <= SEEK;
            hold_left   <= '0;
            left_data   <= '0;
            right_data  <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            valid       <= valid_next;
            frame_error <= ferr_next;
            if (load_hold) begin
                hold_left <= word_q;
            end
            if (load_out) begin
                left_data  <= hold_left;
                right_data <= word_q;
            end
        end
    end

    assign state_dbg = state;

endmodule
